frv_dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the core's dmem request/grant bus.

---
 rtl/frv_dmem_responder_pkg.sv | 28 ++
 rtl/frv_dmem_sram.sv | 30 +++
 rtl/frv_dmem_responder.sv | 119 +++++++++++
 tb/tb_frv_dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_dmem_responder_pkg.sv
// Shared types and constants for the dmem responder: FSM encoding, request
// record, byte-lane geometry and the stall LFSR.
package frv_dmem_responder_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_RESP  = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic                 wen;
    logic [NUM_LANES-1:0] strb;
    logic [31:0]          addr;
    logic [31:0]          wdata;
  } dmem_req_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

endpackage

// File: rtl/frv_dmem_sram.sv
// Single-port synchronous SRAM split into byte lanes; one read or write per
// cycle. Read data register only updates on a read so it holds across writes.
module frv_dmem_sram
  import frv_dmem_responder_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                             g_clk,
  input  logic                             en,
  input  logic                             we,
  input  logic [NUM_LANES-1:0]             be,
  input  logic [AW-1:0]                    idx,
  input  logic [NUM_LANES-1:0][LANE_W-1:0] wdata,
  output logic [NUM_LANES-1:0][LANE_W-1:0] rdata
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] q;

    always_ff @(posedge g_clk) begin
      if (en && we && be[g]) mem[idx] <= wdata[g];
      if (en && !we)         q        <= mem[idx];
    end

    assign rdata[g] = q;
  end

endmodule

// File: rtl/frv_dmem_responder.sv
// Slave end of the dmem req/gnt bus: stall-then-grant FSM, range decode,
// byte-strobed SRAM and a single held response slot.
module frv_dmem_responder
  import frv_dmem_responder_pkg::*;
#(
  parameter int          DEPTH        = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0002_0000,
  parameter int          STALL_CYCLES = 0,
  parameter bit          RAND_STALL   = 1'b0
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_MASK  = ~(32'(DEPTH * 4) - 32'd1);
  localparam logic [3:0]  STALL_MAX = 4'(STALL_CYCLES);

  dmem_state_e state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  lfsr;
  logic [3:0]  stall;
  logic        hit, slot_free, gnt_raw;
  logic        err_q, rd_q;
  logic [NUM_LANES-1:0][LANE_W-1:0] sram_q;
  dmem_req_t   rq;

  assign rq    = '{wen: dmem_wen, strb: dmem_strb, addr: dmem_addr, wdata: dmem_wdata};
  assign stall = RAND_STALL ? (lfsr[3:0] & STALL_MAX) : STALL_MAX;
  assign hit   = (rq.addr & WIN_MASK) == BASE_ADDR;

  assign dmem_recv = (state == ST_RESP);
  assign slot_free = !dmem_recv || dmem_ack;

  // cnt holds the wait cycles still to go; the request cycle itself is the
  // first stall cycle, so a stall of N loads N-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_raw   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dmem_req) begin
          if (stall == 4'd0) begin
            gnt_raw   = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            cnt_nxt   = stall - 4'd1;
            state_nxt = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (!dmem_req)         state_nxt = ST_IDLE;
        else if (cnt != 4'd0)  cnt_nxt   = cnt - 4'd1;
        else if (slot_free) begin
          gnt_raw   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (dmem_ack) begin
          if (!dmem_req)            state_nxt = ST_IDLE;
          else if (stall == 4'd0)   gnt_raw   = 1'b1;
          else begin
            cnt_nxt   = stall - 4'd1;
            state_nxt = ST_STALL;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Masking with reset keeps a write from committing on the reset edge.
  assign dmem_gnt = gnt_raw && !g_reset;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      lfsr  <= LFSR_SEED;
      err_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (dmem_gnt) begin
        lfsr  <= lfsr_step(lfsr);
        err_q <= !hit;
        rd_q  <= hit && !rq.wen;
      end
    end
  end

  frv_dmem_sram #(.DEPTH(DEPTH)) u_sram (
    .g_clk (g_clk),
    .en    (dmem_gnt && hit),
    .we    (rq.wen),
    .be    (rq.strb),
    .idx   (rq.addr[AW+1:2]),
    .wdata (rq.wdata),
    .rdata (sram_q)
  );

  assign dmem_error = dmem_recv && err_q;
  assign dmem_rdata = (dmem_recv && rd_q) ? sram_q : 32'h0;

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Bench for frv_dmem_responder: three instances (no stall, fixed stall 3,
// random stall masked by 7) driven by vector tables, hand sequences and a
// randomized run against a word-array model.
module tb_frv_dmem_responder;

  localparam logic [31:0] BASE = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        wen   [3];
  logic [3:0]  strb  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        gnt   [3];
  logic        recv  [3];
  logic        ack   [3];
  logic        err   [3];
  logic [31:0] rdata [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frv_dmem_responder u0 (
    .g_clk(clk), .g_reset(rst[0]), .dmem_req(req[0]), .dmem_wen(wen[0]),
    .dmem_strb(strb[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
    .dmem_gnt(gnt[0]), .dmem_recv(recv[0]), .dmem_ack(ack[0]),
    .dmem_error(err[0]), .dmem_rdata(rdata[0]));

  frv_dmem_responder #(.STALL_CYCLES(3)) u1 (
    .g_clk(clk), .g_reset(rst[1]), .dmem_req(req[1]), .dmem_wen(wen[1]),
    .dmem_strb(strb[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
    .dmem_gnt(gnt[1]), .dmem_recv(recv[1]), .dmem_ack(ack[1]),
    .dmem_error(err[1]), .dmem_rdata(rdata[1]));

  frv_dmem_responder #(.STALL_CYCLES(7), .RAND_STALL(1'b1)) u2 (
    .g_clk(clk), .g_reset(rst[2]), .dmem_req(req[2]), .dmem_wen(wen[2]),
    .dmem_strb(strb[2]), .dmem_addr(addr[2]), .dmem_wdata(wdata[2]),
    .dmem_gnt(gnt[2]), .dmem_recv(recv[2]), .dmem_ack(ack[2]),
    .dmem_error(err[2]), .dmem_rdata(rdata[2]));

  typedef struct {
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request, wait for gnt and recv, capture response, ack it.
  task automatic txn(input int k, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er,
                     output int lat, output int rlat);
    int n;
    rd = '0; er = 1'b0; lat = -1; rlat = -1;
    @(negedge clk);
    req[k] = 1'b1; wen[k] = w; strb[k] = s; addr[k] = a; wdata[k] = d;
    #1;
    n = 0;
    while (!gnt[k] && n < 40) begin @(negedge clk); #1; n++; end
    if (!gnt[k]) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      req[k] = 1'b0;
      return;
    end
    lat = n;
    @(negedge clk);
    req[k] = 1'b0;
    #1;
    n = 0;
    while (!recv[k] && n < 8) begin @(negedge clk); #1; n++; end
    if (!recv[k]) begin
      chk("recv_timeout", 32'd0, 32'd1);
      return;
    end
    rlat = n; rd = rdata[k]; er = err[k];
    ack[k] = 1'b1;
    @(negedge clk);
    ack[k] = 1'b0;
    #1;
    chk("recv_drop", 32'(recv[k]), 32'd0);
  endtask

  function automatic logic [7:0] lf_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [16];
    logic [31:0] rd, a, d, erd, mdl [16];
    logic        er, w, miss, eer;
    logic [3:0]  s;
    logic [7:0]  lf;
    int          lat, rlat, n, j, elat;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; wen[k] = 1'b0; strb[k] = '0;
      addr[k] = '0; wdata[k] = '0; ack[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_gnt%0d", k),   32'(gnt[k]),  32'd0);
      chk($sformatf("reset_recv%0d", k),  32'(recv[k]), 32'd0);
      chk($sformatf("reset_err%0d", k),   32'(err[k]),  32'd0);
      chk($sformatf("reset_rdata%0d", k), rdata[k],     32'd0);
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // No-stall instance: data, strobes, window edges.
    tbl[0]  = '{1'b1, 4'hF, BASE + 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 4'h0, BASE + 32'h13,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, BASE + 32'h20,  32'h11223344, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 4'h1, BASE + 32'h20,  32'h000000AA, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 4'h0, BASE + 32'h20,  32'h0,        32'h112233AA, 1'b0};
    tbl[5]  = '{1'b1, 4'hC, BASE + 32'h20,  32'hBEEF0000, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 4'h0, BASE + 32'h20,  32'h0,        32'hBEEF33AA, 1'b0};
    tbl[7]  = '{1'b1, 4'h0, BASE + 32'h20,  32'hFFFFFFFF, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 4'h0, BASE + 32'h20,  32'h0,        32'hBEEF33AA, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, BASE,           32'hCAFEF00D, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 4'hF, 32'h0000_1000,  32'h12345678, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 4'h0, 32'h0000_1000,  32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b0, 4'h0, BASE,           32'h0,        32'hCAFEF00D, 1'b0};
    tbl[13] = '{1'b0, 4'h0, BASE + 32'h1000, 32'h0,       32'h0,        1'b1};
    tbl[14] = '{1'b1, 4'hF, BASE + 32'hFFC, 32'h0A0B0C0D, 32'h0,        1'b0};
    tbl[15] = '{1'b0, 4'h0, BASE + 32'hFFC, 32'h0,        32'h0A0B0C0D, 1'b0};
    for (int i = 0; i < 16; i++) begin
      txn(0, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, rd, er, lat, rlat);
      chk($sformatf("tbl%0d_lat", i),   lat,         32'd0);
      chk($sformatf("tbl%0d_rlat", i),  rlat,        32'd0);
      chk($sformatf("tbl%0d_rdata", i), rd,          tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i),   32'(er),     32'(tbl[i].exp_er));
    end

    // Back-to-back: ack and next request in the same cycle.
    @(negedge clk);
    req[0] = 1'b1; wen[0] = 1'b0; addr[0] = BASE + 32'h10;
    #1 chk("b2b_gnt0", 32'(gnt[0]), 32'd1);
    @(negedge clk);
    addr[0] = BASE; ack[0] = 1'b1;
    #1;
    chk("b2b_recv0", 32'(recv[0]), 32'd1);
    chk("b2b_rdata0", rdata[0], 32'hDEADBEEF);
    chk("b2b_gnt1", 32'(gnt[0]), 32'd1);
    @(negedge clk);
    req[0] = 1'b0; ack[0] = 1'b0;
    #1;
    chk("b2b_recv1", 32'(recv[0]), 32'd1);
    chk("b2b_rdata1", rdata[0], 32'hCAFEF00D);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    #1 chk("b2b_drop", 32'(recv[0]), 32'd0);

    // Fixed stall of 3.
    txn(1, 1'b1, 4'hF, BASE + 32'h40, 32'h55AA55AA, rd, er, lat, rlat);
    chk("st3_wr_lat", lat, 32'd3);
    chk("st3_wr_rlat", rlat, 32'd0);
    txn(1, 1'b0, 4'h0, BASE + 32'h40, 32'h0, rd, er, lat, rlat);
    chk("st3_rd_lat", lat, 32'd3);
    chk("st3_rd_data", rd, 32'h55AA55AA);
    txn(1, 1'b1, 4'hF, BASE + 32'h44, 32'h00000066, rd, er, lat, rlat);

    // Withheld ack with a second request pending.
    @(negedge clk);
    req[1] = 1'b1; wen[1] = 1'b0; addr[1] = BASE + 32'h40;
    #1;
    n = 0;
    while (!gnt[1] && n < 40) begin @(negedge clk); #1; n++; end
    chk("hold_gnt_lat", n, 32'd3);
    @(negedge clk);
    addr[1] = BASE + 32'h44;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_recv", i),  32'(recv[1]), 32'd1);
      chk($sformatf("hold%0d_rdata", i), rdata[1],     32'h55AA55AA);
      chk($sformatf("hold%0d_gnt", i),   32'(gnt[1]),  32'd0);
      @(negedge clk); #1;
    end
    ack[1] = 1'b1;
    #1 chk("hold_ack_gnt", 32'(gnt[1]), 32'd0);
    @(negedge clk);
    ack[1] = 1'b0;
    #1 chk("hold_after_ack_recv", 32'(recv[1]), 32'd0);
    n = 1;
    while (!gnt[1] && n < 40) begin @(negedge clk); #1; n++; end
    chk("hold_second_lat", n, 32'd3);
    @(negedge clk);
    req[1] = 1'b0;
    #1;
    chk("hold_second_recv", 32'(recv[1]), 32'd1);
    chk("hold_second_rdata", rdata[1], 32'h00000066);
    ack[1] = 1'b1;
    @(negedge clk);
    ack[1] = 1'b0;

    // Reset while stalling: write must not commit.
    @(negedge clk);
    req[1] = 1'b1; wen[1] = 1'b1; strb[1] = 4'hF;
    addr[1] = BASE + 32'h40; wdata[1] = 32'hBAD0BAD0;
    @(negedge clk);
    #1 chk("rst_stall_pre_gnt", 32'(gnt[1]), 32'd0);
    rst[1] = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("rst_stall_gnt",   32'(gnt[1]),  32'd0);
    chk("rst_stall_recv",  32'(recv[1]), 32'd0);
    chk("rst_stall_err",   32'(err[1]),  32'd0);
    chk("rst_stall_rdata", rdata[1],     32'd0);
    txn(1, 1'b0, 4'h0, BASE + 32'h40, 32'h0, rd, er, lat, rlat);
    chk("rst_stall_keep", rd, 32'h55AA55AA);

    // Reset while a response is held.
    @(negedge clk);
    req[1] = 1'b1; wen[1] = 1'b0; addr[1] = BASE + 32'h44;
    #1;
    n = 0;
    while (!gnt[1] && n < 40) begin @(negedge clk); #1; n++; end
    chk("rst_resp_gnt_lat", n, 32'd3);
    @(negedge clk);
    req[1] = 1'b0;
    #1 chk("rst_resp_pre_rdata", rdata[1], 32'h00000066);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("rst_resp_gnt",   32'(gnt[1]),  32'd0);
    chk("rst_resp_recv",  32'(recv[1]), 32'd0);
    chk("rst_resp_err",   32'(err[1]),  32'd0);
    chk("rst_resp_rdata", rdata[1],     32'd0);
    txn(1, 1'b0, 4'h0, BASE + 32'h44, 32'h0, rd, er, lat, rlat);
    chk("rst_resp_keep", rd, 32'h00000066);

    // Random stall instance vs word-array model; stall = lfsr[3:0] & 7.
    lf = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      elat = int'(lf[3:0] & 4'd7);
      txn(2, 1'b1, 4'hF, BASE + 32'(i * 4), mdl[i], rd, er, lat, rlat);
      chk($sformatf("fill%0d_lat", i), lat, elat);
      lf = lf_next(lf);
    end
    for (int i = 0; i < 100; i++) begin
      w    = 1'($urandom_range(0, 1));
      s    = 4'($urandom);
      j    = $urandom_range(0, 15);
      miss = ($urandom_range(0, 7) == 0);
      d    = $urandom;
      a    = (miss ? 32'h0004_0000 : BASE) + 32'(j * 4) + 32'($urandom_range(0, 3));
      elat = int'(lf[3:0] & 4'd7);
      erd  = 32'h0;
      eer  = miss;
      if (!miss && w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[j][8*b +: 8] = d[8*b +: 8];
      end else if (!miss) begin
        erd = mdl[j];
      end
      txn(2, w, s, a, d, rd, er, lat, rlat);
      chk($sformatf("rnd%0d_lat", i),   lat,     elat);
      chk($sformatf("rnd%0d_rdata", i), rd,      erd);
      chk($sformatf("rnd%0d_err", i),   32'(er), 32'(eer));
      lf = lf_next(lf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
